// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, wait-state bound.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WAIT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dm_lane.sv
// Combinational lane logic: store byte-enable/data steering, load extraction/extension and
// misalignment detection (detection only exists when DM_ALIGN_CHECK_EN is defined).
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  lane_en,
    output logic [31:0] wword,
    output logic [31:0] rext,
    output logic        misaligned
);

    logic [1:0]  off;
    logic [31:0] shifted;

    // Without the alignment check, the low offset bits are masked so a misaligned
    // half/word silently lands on its naturally aligned container.
    always_comb begin
        off        = 2'b00;
        lane_en    = 4'b1111;
        wword      = wdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                off     = offset;
                lane_en = 4'b0001 << offset;
                wword   = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                off     = {offset[1], 1'b0};
                lane_en = 4'b0011 << {offset[1], 1'b0};
                wword   = {2{wdata[15:0]}};
`ifdef DM_ALIGN_CHECK_EN
                misaligned = offset[0];
`endif
            end
            default: begin
                off = 2'b00;
`ifdef DM_ALIGN_CHECK_EN
                misaligned = |offset;
`endif
            end
        endcase
    end

    always_comb begin
        shifted = rword >> {off, 3'b000};
        case (size)
            SZ_BYTE: rext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: rext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: rext = rword;
        endcase
    end

endmodule

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder (req/ack) with byte/half/word little-endian access.
// Define DM_ALIGN_CHECK_EN to reject misaligned accesses with addr_err instead of masking.
module dm_resp
    import dm_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WAITS = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
    localparam logic [3:0] CNT_LOAD = 4'((WAITS > 0) ? WAITS - 1 : 0);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    lane_en;
    logic [31:0]   wword;
    logic [31:0]   rext;
    logic          misaligned;
    logic          go_resp;
    logic          unused_addr_hi;

    assign idx            = addr[AW+1:2];
    assign rword          = mem[idx];
    assign unused_addr_hi = ^addr[31:AW+2];

    dm_lane u_lane (
        .size       (size),
        .sign_ext   (sign_ext),
        .offset     (addr[1:0]),
        .wdata      (wdata),
        .rword      (rword),
        .lane_en    (lane_en),
        .wword      (wword),
        .rext       (rext),
        .misaligned (misaligned)
    );

    // The edge that enters RESP is where the store commits and the load is captured.
    assign go_resp = ((state == ST_IDLE) && req && (WAITS == 0)) ||
                     ((state == ST_WAIT) && (cnt == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            ack      <= 1'b0;
            rdata    <= 32'd0;
            addr_err <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (WAITS == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (go_resp) begin
                ack      <= 1'b1;
                addr_err <= misaligned;
                rdata    <= (misaligned || we) ? 32'd0 : rext;
            end
        end
    end

    // Storage has no reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && we && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: two instances (0 and 3 wait states) checked against a byte-level memory model.
module tb_dm_resp;

    localparam int W0 = 0;
    localparam int W1 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req      [2];
    logic        we       [2];
    logic [1:0]  size     [2];
    logic        sign_ext [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic        ack      [2];
    logic [31:0] rdata    [2];
    logic        addr_err [2];

    always #5 clk = ~clk;

    dm_resp #(.DEPTH(1024), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .size(size[0]),
        .sign_ext(sign_ext[0]), .addr(addr[0]), .wdata(wdata[0]),
        .ack(ack[0]), .rdata(rdata[0]), .addr_err(addr_err[0])
    );

    dm_resp #(.DEPTH(1024), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .size(size[1]),
        .sign_ext(sign_ext[1]), .addr(addr[1]), .wdata(wdata[1]),
        .ack(ack[1]), .rdata(rdata[1]), .addr_err(addr_err[1])
    );

    typedef struct {
        int          d;
        int          cyc;
        logic        is_load;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [2][1024];
    int          cyc = 0;
    int          free_edge [2];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        hit;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int waits(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    // Reference: memory is an array of bytes per word; an access touches n consecutive bytes.
    function automatic void model_access(input int d, input logic w, input logic [1:0] sz,
                                         input logic se, input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int n, off, idx;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        idx = int'((a / 4) % 1024);
        rd  = 32'd0;
        err = 1'b0;
        if (off % n != 0) begin
`ifdef DM_ALIGN_CHECK_EN
            err = 1'b1;
            return;
`else
            off = off - off % n;
`endif
        end
        if (w) begin
            for (int i = 0; i < n; i++) mdl[d][idx][8*(off+i) +: 8] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[d][idx][8*(off+i) +: 8];
            if (se && n < 4 && v[8*n-1]) begin
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            rd = v;
        end
    endfunction

    // Called at a negedge; returns at the negedge where ack is due, leaving req low.
    task automatic access(input int d, input logic w, input logic [1:0] sz, input logic se,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd_seen, output logic err_seen);
        exp_t        e;
        int          acc;
        logic [31:0] m_rd;
        logic        m_err;
        req[d] = 1'b1; we[d] = w; size[d] = sz; sign_ext[d] = se; addr[d] = a; wdata[d] = wd;
        acc = (cyc + 1 > free_edge[d]) ? cyc + 1 : free_edge[d];
        model_access(d, w, sz, se, a, wd, m_rd, m_err);
        e.d = d; e.cyc = acc + waits(d); e.is_load = !w; e.rd = m_rd; e.err = m_err;
        exp_q.push_back(e);
        free_edge[d] = e.cyc + 2;
        while (cyc < e.cyc) @(negedge clk);
        rd_seen  = rdata[d];
        err_seen = addr_err[d];
        req[d]   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                hit = (exp_q.size() > 0) && (exp_q[0].d == d) && (exp_q[0].cyc == cyc);
                n_cmp++;
                if (ack[d] !== hit) begin
                    n_fail++;
                    $display("FAIL ack_dut%0d: got %b expected %b (cyc %0d)", d, ack[d], hit, cyc);
                end
                if (hit) begin
                    n_cmp++;
                    if (addr_err[d] !== exp_q[0].err) begin
                        n_fail++;
                        $display("FAIL addr_err_dut%0d: got %b expected %b (cyc %0d)",
                                 d, addr_err[d], exp_q[0].err, cyc);
                    end
                    if (exp_q[0].is_load || exp_q[0].err) begin
                        n_cmp++;
                        if (rdata[d] !== exp_q[0].rd) begin
                            n_fail++;
                            $display("FAIL rdata_dut%0d: got %h expected %h (cyc %0d)",
                                     d, rdata[d], exp_q[0].rd, cyc);
                        end
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          c0, a1, a2;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'd0; sign_ext[d] = 1'b0;
            addr[d] = 32'd0; wdata[d] = 32'd0; free_edge[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ack%0d", d), {31'd0, ack[d]}, 32'd0);
            chk($sformatf("reset_rdata%0d", d), rdata[d], 32'd0);
            chk($sformatf("reset_err%0d", d), {31'd0, addr_err[d]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Zero wait states: words, bytes, halves.
        c0 = cyc;
        access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
        chk("sw_latency", cyc - c0, 32'd1);
        access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er);
        chk("lw_10", rd, 32'hDEADBEEF);
        chk("lw_10_err", {31'd0, er}, 32'd0);

        access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        access(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h80, rd, er);
        access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        chk("lw_20_after_sb", rd, 32'h00008000);
        access(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, rd, er);
        chk("lb_21", rd, 32'hFFFFFF80);
        access(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd, er);
        chk("lbu_21", rd, 32'h00000080);
        access(0, 1'b1, 2'd0, 1'b0, 32'h22, 32'hFFFFFF7F, rd, er);
        access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        chk("sb_lane_preserve", rd, 32'h007F8000);

        access(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, rd, er);
        access(0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h1234F00D, rd, er);
        access(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er);
        chk("lw_30_after_sh", rd, 32'hF00D0000);
        access(0, 1'b0, 2'd1, 1'b1, 32'h32, 32'h0, rd, er);
        chk("lh_32", rd, 32'hFFFFF00D);
        access(0, 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, rd, er);
        chk("lhu_32", rd, 32'h0000F00D);

        // Misaligned accesses.
        access(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, rd, er);
`ifdef DM_ALIGN_CHECK_EN
        chk("lw_13_err", {31'd0, er}, 32'd1);
        chk("lw_13_rdata", rd, 32'h0);
`else
        chk("lw_13_err", {31'd0, er}, 32'd0);
        chk("lw_13_rdata", rd, 32'hDEADBEEF);
`endif
        access(0, 1'b1, 2'd1, 1'b0, 32'h31, 32'h0000ABCD, rd, er);
        access(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er);
`ifdef DM_ALIGN_CHECK_EN
        chk("sh_31_effect", rd, 32'hF00D0000);
`else
        chk("sh_31_effect", rd, 32'hF00DABCD);
`endif

        // Store then immediate load of the same word; address wrap; size 11 as word.
        access(0, 1'b1, 2'd2, 1'b0, 32'h50, 32'h11223344, rd, er);
        access(0, 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, rd, er);
        chk("st_ld_forward", rd, 32'h11223344);
        access(0, 1'b1, 2'd2, 1'b0, 32'h1060, 32'hCAFEF00D, rd, er);
        access(0, 1'b0, 2'd3, 1'b0, 32'h60, 32'h0, rd, er);
        chk("wrap_size3", rd, 32'hCAFEF00D);

        // Three wait states, back-to-back.
        c0 = cyc;
        access(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, rd, er);
        a1 = cyc;
        chk("w3_latency", a1 - c0, 32'd4);
        access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er);
        a2 = cyc;
        chk("w3_ack_spacing", a2 - a1, 32'd5);
        chk("w3_lw_40", rd, 32'h12345678);
        access(1, 1'b0, 2'd0, 1'b1, 32'h43, 32'h0, rd, er);
        chk("w3_lb_43", rd, 32'h00000012);

        // Reset pulsed while a store sits in WAIT.
        req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'd2; sign_ext[1] = 1'b0;
        addr[1] = 32'h40; wdata[1] = 32'h55;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req[1] = 1'b0;
        chk("abort_ack", {31'd0, ack[1]}, 32'd0);
        chk("abort_rdata", rdata[1], 32'd0);
        chk("abort_err", {31'd0, addr_err[1]}, 32'd0);
        free_edge[1] = cyc + 1;
        repeat (6) @(negedge clk);
        access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er);
        chk("abort_word_kept", rd, 32'h12345678);
        free_edge[0] = cyc + 1;
        access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
        chk("storage_survives_reset", rd, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_resp.md
# dm_resp

Multi-cycle data-memory responder that serves load/store requests from the multi-cycle MIPS core over a req/ack handshake. Supports byte, halfword and word accesses, so `lb/lbu/lh/lhu/lw/sb/sh/sw` can all complete here. Read data is returned sign- or zero-extended to 32 bits. Sits between the core's memory-stage control (the initiator) and a word-organised, little-endian storage array.

## Interface
Parameters:
- `DEPTH`, 1024: storage size in 32-bit words; must be a power of two.
- `WAIT_CYCLES`, 0: extra wait states inserted before `ack`; range 0..15.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input 1: request valid; the initiator holds `req` and all request fields stable until `ack`.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `sign_ext` input 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ack` output 1: one-cycle pulse; the request is complete.
- `rdata` output 32: extended load data; valid only while `ack`=1.
- `addr_err` output 1: qualifies `ack`; 1 = misaligned access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE → WAIT when `req`=1 and `WAIT_CYCLES`>0; the wait counter loads `WAIT_CYCLES`-1.
- IDLE → RESP when `req`=1 and `WAIT_CYCLES`=0.
- WAIT decrements the counter and goes to RESP when the counter is 0.
- RESP always returns to IDLE. `req` is ignored in RESP.
- Storage:
  - Index = `addr[log2(DEPTH)+1:2]`; higher address bits are ignored, so accesses wrap modulo DEPTH words.
  - Little-endian lanes: byte offset `addr[1:0]`=0 maps to bits [7:0].
- Store:
  - Data is written on the edge that enters RESP.
  - Only the addressed lanes are written: byte → 1 lane; half → lanes {`addr[1]`*2, +1}; word → all 4. Other lanes are preserved.
- Load:
  - The word is read and lane-extracted on the edge that enters RESP.
  - Byte/half are extended per `sign_ext`; word ignores `sign_ext`.
- Misalignment (see Configuration): half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Storage is not cleared by reset.

## Timing
- Reset values: `ack`=0, `rdata`=0, `addr_err`=0, state = IDLE, wait counter = 0.
- Latency: `req` first sampled high at edge N → `ack` high during cycle N+1+`WAIT_CYCLES`, for exactly one cycle.
- `rdata` and `addr_err` are registered. They hold their last values when `ack`=0; the verifier checks them only with `ack`.
- Back-to-back requests: if `req` is still high in the cycle after `ack`, it is a new request. Throughput is at most one access per 2+`WAIT_CYCLES` cycles.
- Reset asserted in WAIT or RESP aborts the access:
  - No store is performed unless the store edge already occurred.
  - `ack` is never issued for the aborted request.
- A store followed immediately by a load to the same word returns the new data.

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - Misaligned accesses complete normally through the FSM, with `ack`=1 and `addr_err`=1.
  - Storage is untouched; `rdata`=0.
- Macro undefined:
  - Alignment bits are masked: half uses `addr[1]`, word ignores `addr[1:0]`.
  - `addr_err` is tied to 0.

## Structure
- `dm_pkg` holds:
  - the size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state encodings;
  - the `WAIT_CYCLES` upper bound constant.
- Sub-module `dm_lane` is natural here. It is combinational and does:
  - store lane-mask/data steering;
  - load extraction and extension;
  - misalignment detection.
- The top level holds the FSM, the counter, the storage array and the output registers.

## Test plan
- Word store/load, `WAIT_CYCLES`=0:
  - sw 0xDEADBEEF to 0x10 → `ack` at N+1; then lw 0x10 → `rdata`=0xDEADBEEF, `addr_err`=0.
- Byte lanes and extension:
  - sb 0x80 to 0x21 over word 0x00000000 → lw 0x20 returns 0x00008000.
  - lb 0x21 with `sign_ext`=1 → 0xFFFFFF80; lbu (`sign_ext`=0) → 0x00000080.
- Halfword: sh 0xF00D to 0x32 → lw 0x30 = 0xF00D0000; lh 0x32 → 0xFFFFF00D.
- Wait states and back-to-back:
  - With `WAIT_CYCLES`=3 and `req` held: each `ack` arrives 4 cycles after acceptance, separated by 5 cycles.
- Misalignment: lw at 0x13 and sh at 0x31.
  - With `DM_ALIGN_CHECK_EN`: `ack`=1, `addr_err`=1, and memory is unchanged.
  - Without it: the accesses hit 0x10 and 0x30.
- Reset mid-access: `WAIT_CYCLES`=3, `rst` pulsed during WAIT of sw 0x55 to 0x40 → no `ack`, word 0x40 unchanged, all outputs 0.
